prime_check: RTL

- Trial-division primality tester; sits directly upstream of the divmod stage and drives it.
- Takes a candidate n and issues successive divisions n / d for d = 2, 3, ... on the divmod request/result ports.
- Consumes divmod's quotient and remainder to decide prime or composite and report the smallest factor.
- Terminates at d > sqrt(n) using the quotient (q <= d), so no multiplier is needed.

---
 rtl/prime_check_if.sv | 30 +++
 rtl/prime_check.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prime_check_if.sv
// prime_check_if: request/result link between prime_check and the divmod stage.
//   dm_go    : request pulse to divmod (rising edge starts a division)
//   dm_a     : dividend
//   dm_b     : divisor
//   dm_ready : divmod idle / result valid
//   dm_error : divmod flagged an error for the last division
//   dm_div   : quotient
//   dm_mod   : remainder
// master = prime_check side, slave = divmod side.
interface prime_check_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             dm_go;
  logic [WIDTH-1:0] dm_a;
  logic [WIDTH-1:0] dm_b;
  logic             dm_ready;
  logic             dm_error;
  logic [WIDTH-1:0] dm_div;
  logic [WIDTH-1:0] dm_mod;

  modport master (
    output dm_go, dm_a, dm_b,
    input  dm_ready, dm_error, dm_div, dm_mod
  );

  modport slave (
    input  dm_go, dm_a, dm_b,
    output dm_ready, dm_error, dm_div, dm_mod
  );
endinterface

// File: rtl/prime_check.sv
// prime_check: trial-division primality tester driving an attached divmod.
// A rising edge on go launches a check of n. Divisors d = 2, 3, ... are
// issued to divmod; the check ends on the first exact division with q >= d
// (composite, factor = d) or when q <= d (no divisor can remain, prime).
//   clk, rst      : clock, synchronous active-high reset
//   go, n         : launch strobe (edge-detected) and candidate
//   ready         : idle / result valid
//   prime, factor : result; factor is the smallest divisor, 0 if prime or n < 2
//   error         : divmod reported an error during the check
//   dm            : divmod request/result link (prime_check_if.master)
// Build option: define PRIME_CHECK_ODD_STEP_EN to step d by 2 after d = 2
// (2, 3, 5, 7, ...). Results are unchanged; only the division count drops.
module prime_check #(
  parameter int unsigned WIDTH_LOG = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  input  logic [(1<<WIDTH_LOG)-1:0]   n,
  output logic                        ready,
  output logic                        prime,
  output logic [(1<<WIDTH_LOG)-1:0]   factor,
  output logic                        error,
  prime_check_if.master               dm
);
  localparam int unsigned WIDTH = 1 << WIDTH_LOG;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    DONE
  } state_e;

  state_e           state_q,  state_d;
  logic             ready_q,  ready_d;
  logic             prime_q,  prime_d;
  logic [WIDTH-1:0] factor_q, factor_d;
  logic             error_q,  error_d;
  logic             dm_go_q,  dm_go_d;
  logic [WIDTH-1:0] dm_b_q,   dm_b_d;
  logic             go_prev_q, go_prev_d;
  logic [WIDTH-1:0] n_reg_q,  n_reg_d;
  logic [WIDTH-1:0] d_q,      d_d;

  logic             launch;
  logic [WIDTH-1:0] d_next;

  // Launches only while idle/finished; go_prev tracks go regardless so a
  // level held across completion never relaunches.
  assign launch = go && !go_prev_q && ready_q;

`ifdef PRIME_CHECK_ODD_STEP_EN
  // From 2 step to 3, then stay on odd divisors.
  assign d_next = d_q + (d_q[0] ? WIDTH'(2) : WIDTH'(1));
`else
  assign d_next = d_q + WIDTH'(1);
`endif

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    prime_d   = prime_q;
    factor_d  = factor_q;
    error_d   = error_q;
    dm_go_d   = 1'b0;
    dm_b_d    = dm_b_q;
    go_prev_d = go;
    n_reg_d   = n_reg_q;
    d_d       = d_q;

    case (state_q)
      IDLE, DONE: begin
        // ready is low for one cycle after an n < 2 launch, then returns.
        ready_d = 1'b1;
        if (launch) begin
          n_reg_d  = n;
          ready_d  = 1'b0;
          prime_d  = 1'b0;
          factor_d = '0;
          error_d  = 1'b0;
          if (n < WIDTH'(2)) begin
            state_d = DONE;
          end else begin
            d_d     = WIDTH'(2);
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        dm_go_d = 1'b1;
        dm_b_d  = d_q;
        state_d = SETTLE;
      end

      // divmod's ready is still stale here; it drops one cycle after the edge.
      SETTLE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (dm.dm_ready) begin
          if (dm.dm_error) begin
            error_d = 1'b1;
            prime_d = 1'b0;
            ready_d = 1'b1;
            state_d = DONE;
          end else if ((dm.dm_mod == '0) && (dm.dm_div >= d_q)) begin
            factor_d = d_q;
            prime_d  = 1'b0;
            ready_d  = 1'b1;
            state_d  = DONE;
          end else if (dm.dm_div <= d_q) begin
            // q <= d with no exact hit implies n < (d+1)^2: nothing left to try.
            prime_d  = 1'b1;
            factor_d = '0;
            ready_d  = 1'b1;
            state_d  = DONE;
          end else begin
            d_d     = d_next;
            state_d = ISSUE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      prime_q   <= 1'b0;
      factor_q  <= '0;
      error_q   <= 1'b0;
      dm_go_q   <= 1'b0;
      dm_b_q    <= '0;
      go_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      prime_q   <= prime_d;
      factor_q  <= factor_d;
      error_q   <= error_d;
      dm_go_q   <= dm_go_d;
      dm_b_q    <= dm_b_d;
      go_prev_q <= go_prev_d;
    end
  end

  // Datapath registers are only meaningful after a launch; left unreset.
  always_ff @(posedge clk) begin
    n_reg_q <= n_reg_d;
    d_q     <= d_d;
  end

  assign ready    = ready_q;
  assign prime    = prime_q;
  assign factor   = factor_q;
  assign error    = error_q;
  assign dm.dm_go = dm_go_q;
  assign dm.dm_a  = n_reg_q;
  assign dm.dm_b  = dm_b_q;
endmodule
